// File: rtl/display_pkg.sv
// Shared types and constants for the result display.
// Segment patterns are gfedcba, active-low.
package display_pkg;

  localparam int VAL_W = 11;
  localparam int MAG_W = VAL_W + 1;
  localparam int BCD_W = 16;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg_digit(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle,
// result valid on bcd while done is high.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             busy,
  output logic             load,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] LAST = 4'(MAG_W - 1);

  conv_state_t      state;
  conv_state_t      state_nx;
  logic [MAG_W-1:0] mag;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [3:0]       cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = LOAD;
      LOAD:   state_nx = SHIFT;
      SHIFT:  if (cnt == LAST) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        mag <= bin;
        acc <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {acc, mag} <= {acc_adj, mag} << 1;
        cnt        <= cnt + 4'd1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign load = (state == LOAD);
  assign done = (state == COMMIT);
  assign bcd  = acc;

endmodule

// File: rtl/result_display.sv
// Signed result to four-digit multiplexed seven-segment
// display: change detect, digit mapping and refresh scan.
module result_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] data_in,
  input  logic             err,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             busy
);

  localparam int DIV_W =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(REFRESH_DIV - 1);

  logic             pending;
  logic             c_err;
  logic [VAL_W-1:0] c_val;
  logic             err_q;
  logic [VAL_W-1:0] val_q;
  logic [3:0][6:0]  disp;
  logic [3:0][6:0]  disp_nx;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic             wrap;

  logic             start;
  logic             load;
  logic             done;
  logic [MAG_W-1:0] ext;
  logic [MAG_W-1:0] mag_in;
  logic [BCD_W-1:0] bcd;

  assign start = pending
              || ({err, data_in} != {c_err, c_val});

  // 12 bits so that -1024 has a representable magnitude
  assign ext    = {data_in[VAL_W-1], data_in};
  assign mag_in = data_in[VAL_W-1] ? (~ext + 1'b1) : ext;

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag_in),
    .busy  (busy),
    .load  (load),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    disp_nx = {4{SEG_BLANK}};
    if (err_q || (bcd[15:12] != 4'd0)) begin
      disp_nx[3] = SEG_E;
      disp_nx[2] = SEG_R;
      disp_nx[1] = SEG_R;
    end else begin
      if (val_q[VAL_W-1])
        disp_nx[3] = SEG_MINUS;
      if (bcd[11:8] != 4'd0)
        disp_nx[2] = seg_digit(bcd[11:8]);
      if (bcd[11:4] != 8'd0)
        disp_nx[1] = seg_digit(bcd[7:4]);
      disp_nx[0] = seg_digit(bcd[3:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b1;
      c_err   <= 1'b0;
      c_val   <= '0;
      err_q   <= 1'b0;
      val_q   <= '0;
      disp    <= {4{SEG_BLANK}};
    end else begin
      if (load) begin
        val_q <= data_in;
        err_q <= err;
      end
      if (done) begin
        disp    <= disp_nx;
        c_val   <= val_q;
        c_err   <= err_q;
        pending <= 1'b0;
      end
    end
  end

  assign wrap = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      an  <= ~(4'b0001 << idx);
      seg <= disp[idx];
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display against a
// digit-level reference model, REFRESH_DIV = 4.
module tb_result_display;

  localparam int N = 4;

  localparam logic [6:0] TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };
  localparam logic [6:0] T_MIN = 7'b0111111;
  localparam logic [6:0] T_E   = 7'b0000110;
  localparam logic [6:0] T_R   = 7'b0101111;
  localparam logic [6:0] T_BL  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] data_in;
  logic        err;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [10:0] lv;
  logic        le;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .err     (err),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  // {digit3, digit2, digit1, digit0}
  function automatic logic [27:0] model(
    input logic [10:0] v,
    input logic        e
  );
    int sv;
    int m;
    logic [6:0] d3, d2, d1, d0;
    sv = $signed(v);
    m  = (sv < 0) ? -sv : sv;
    if (e || m > 999)
      return {T_E, T_R, T_R, T_BL};
    d3 = (sv < 0) ? T_MIN : T_BL;
    d2 = (m >= 100) ? TAB[m / 100] : T_BL;
    d1 = (m >= 10) ? TAB[(m / 10) % 10] : T_BL;
    d0 = TAB[m % 10];
    return {d3, d2, d1, d0};
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic run_conv(output int lat, output int hi);
    lat = 0;
    hi  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) hi++;
    end while ((hi == 0 || busy) && lat < 60);
    if (lat >= 60) check("conv_timeout", 0, 1);
  endtask

  task automatic scan(
    input logic [10:0] v,
    input logic        e,
    input string       tag
  );
    logic [27:0] exp;
    logic [6:0]  got [4];
    logic [3:0]  prev;
    int          run;
    int          k;
    bit          first;
    bit          seq_ok;
    bit          dwell_ok;
    exp = model(v, e);
    for (int i = 0; i < 4; i++) got[i] = 'x;
    repeat (2) @(negedge clk);
    prev     = an;
    run      = 0;
    first    = 1;
    seq_ok   = 1;
    dwell_ok = 1;
    for (int c = 0; c < 6 * N; c++) begin
      @(negedge clk);
      if (an != prev) begin
        if (an != {prev[2:0], prev[3]}) seq_ok = 0;
        if (!first && run != N) dwell_ok = 0;
        first = 0;
        run   = 0;
        prev  = an;
      end
      run++;
      k = an_idx(an);
      if (k < 0) seq_ok = 0;
      else got[k] = seg;
    end
    check($sformatf("%s_an_seq", tag), 32'(seq_ok), 1);
    check($sformatf("%s_dwell", tag), 32'(dwell_ok), 1);
    for (int i = 3; i >= 0; i--)
      check($sformatf("%s_d%0d", tag, i),
            32'(got[i]), 32'(exp[7*i +: 7]));
  endtask

  task automatic apply(
    input logic [10:0] v,
    input logic        e,
    input string       tag
  );
    int lat;
    int hi;
    data_in = v;
    err     = e;
    lv      = v;
    le      = e;
    run_conv(lat, hi);
    check($sformatf("%s_lat", tag), lat, 15);
    check($sformatf("%s_busy", tag), hi, 14);
    scan(v, e, tag);
  endtask

  logic [10:0] bnd [6] = '{
    11'h400, 11'd1023, 11'd1000, 11'h419, 11'd100, 11'd10
  };

  initial begin
    int          lat;
    int          hi;
    int          cnt;
    int          k;
    bit          ok;
    logic [27:0] exp5;
    logic [10:0] v;
    logic        e;

    rst     = 1'b1;
    data_in = 11'd0;
    err     = 1'b0;
    lv      = 11'd0;
    le      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 1);
    check("rst_busy", 32'(busy), 0);

    rst = 1'b0;
    run_conv(lat, hi);
    check("first_lat", lat, 15);
    check("first_busy", hi, 14);
    scan(11'd0, 1'b0, "zero");

    apply(11'h7F9, 1'b0, "neg7");
    apply(11'd999, 1'b0, "p999");
    apply(11'd40, 1'b0, "p40");
    apply(11'h418, 1'b0, "n1000");
    apply(11'd123, 1'b1, "e123");

    data_in = 11'd123;
    err     = 1'b1;
    repeat (3) @(negedge clk);
    check("same_idle", 32'(busy), 0);

    // change input during the third SHIFT cycle
    data_in = 11'd5;
    err     = 1'b0;
    repeat (4) @(negedge clk);
    data_in = 11'd306;
    cnt = 0;
    while (busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    check("reconv", 32'(busy), 1);
    exp5 = model(11'd5, 1'b0);
    ok   = 1;
    cnt  = 0;
    while (busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
      k = an_idx(an);
      if (k < 0 || seg != exp5[7*k +: 7]) ok = 0;
    end
    check("mid_show5", 32'(ok), 1);
    lv = 11'd306;
    le = 1'b0;
    scan(11'd306, 1'b0, "p306");

    // reset in the middle of SHIFT
    data_in = 11'h600;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_seg", 32'(seg), 32'h7F);
    check("mrst_busy", 32'(busy), 0);
    rst = 1'b0;
    run_conv(lat, hi);
    check("mrst_lat", lat, 15);
    lv = 11'h600;
    le = 1'b0;
    scan(11'h600, 1'b0, "n512");

    foreach (bnd[i])
      apply(bnd[i], 1'b0, $sformatf("bnd%0d", i));

    for (int i = 0; i < 20; i++) begin
      v = 11'($urandom);
      e = ($urandom_range(0, 7) == 0);
      if ({e, v} == {le, lv}) v = v ^ 11'd1;
      apply(v, e, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
